key_event_ctrl: RTL and testbench
=================================

// Module: key_event_ctrl
// PURPOSE
//   Turns debounced press/level pairs from NUM_KEYS key debounce filters into short, long and
//   double-click events. Per-key timing FSMs feed a round-robin arbiter, which puts one event
//   at a time on a single valid/ready port for the UI/menu logic. Sits between the per-key
//   debounce filters and the application control FSM.
// PARAMETERS
//   NUM_KEYS   4           number of keys (1..16)
//   KEY_W      2           width of evt_key, >= clog2(NUM_KEYS), min 1
//   LONG_CNT   50_000_000  hold cycles that make a long press (1 s @ 50 MHz)
//   DBL_CNT    15_000_000  max release-to-repress gap for a double click (300 ms)
//   REPEAT_CNT 10_000_000  auto-repeat period while held (KEY_EVT_REPEAT_EN only)
//   CNT_WIDTH  26          per-key timer width; must hold max(LONG,DBL,REPEAT)_CNT-1
// PORTS
//   clk        in  1         system clock
//   rst_n      in  1         asynchronous active-low reset
//   key_state  in  NUM_KEYS  debounced level per key, 1 = pressed
//   key_flag   in  NUM_KEYS  1-cycle press pulse per key (coincides with key_state rise)
//   evt_valid  out 1         event available
//   evt_ready  in  1         consumer accepts when evt_valid & evt_ready
//   evt_key    out KEY_W     index of key for current event
//   evt_type   out 2         01 short, 10 long, 11 double, 00 repeat
//   ovf_pulse  out 1         1-cycle pulse: an unaccepted pending event was overwritten
// BEHAVIOUR
//   Design: one clock, clk. Reset is asynchronous and active-low (rst_n).
//   Reset: all outputs 0, all FSMs IDLE, timers 0, pending slots empty, rr pointer 0.
//   Release: key_state_d=1 & key_state=0, using a registered copy of key_state.
//   Per-key FSM (timer cnt counts up 1 per cycle in PRESSED/WAIT_DBL/HELD, cleared on entry):
//     IDLE     : key_flag -> PRESSED.
//     PRESSED  : cnt==LONG_CNT-1 -> post LONG. If released the same cycle -> IDLE,
//                else -> HELD. Release with cnt<LONG_CNT-1 -> WAIT_DBL.
//     WAIT_DBL : key_flag -> post DOUBLE, -> HELD. cnt==DBL_CNT-1 -> post SHORT, -> IDLE.
//                If both occur in the same cycle, key_flag wins.
//     HELD     : release -> IDLE (no event).
//   Post: the per-key pending slot {valid,type} is written on the same edge as the transition.
//     A slot that is already valid is overwritten and ovf_pulse=1 on the next cycle.
//   Arbiter: output register is free when !evt_valid or (evt_valid & evt_ready).
//     When free and any slot is valid, grant the first valid slot searching upward from the
//     rr pointer, with wrap. Load evt_key/evt_type, evt_valid=1, clear that slot,
//     rr = grant+1 mod NUM_KEYS.
//     Back-to-back accepts sustain 1 event/cycle with no bubble.
//   Latency: event condition at edge N -> slot valid after N -> evt_valid after N+1.
//   If the output is free, there is no other traffic, and a slot set collides with that
//     key's grant clear in the same cycle, the set wins.
//   evt_key and evt_type are stable while evt_valid & !evt_ready. evt_valid drops only
//     after acceptance.
//   Reset mid-operation drops every in-flight and pending event; no event follows reset.
// CONFIGURATION
//   KEY_EVT_REPEAT_EN defined: in HELD after a LONG (not after a DOUBLE), cnt wraps at
//     REPEAT_CNT-1 and posts a REPEAT (type 00) each wrap until release.
//   KEY_EVT_REPEAT_EN undefined: HELD only waits for release. Type 00 is never produced and
//     the repeat logic is absent.
// TESTING  (NUM_KEYS=4, LONG_CNT=100, DBL_CNT=30, REPEAT_CNT=20, evt_ready=1 unless stated)
//   1. Key1 press, hold 20 cycles, release, no repress
//        -> one evt key=1 type=01, 30 cycles after release (+2 latency).
//   2. Key0 hold 150 cycles -> one type=10 at hold cycle 100; nothing at release.
//      With KEY_EVT_REPEAT_EN: type=00 at 120 and 140.
//   3. Key2 press 10, release, repress after 12 cycles
//        -> single type=11 at the repress; no SHORT; nothing at the final release.
//   4. Keys 0..3 post the same cycle, evt_ready=0 for 10 cycles then 1
//        -> key0 event held stable, then keys 1,2,3 on consecutive cycles, ovf_pulse=0.
//   5. evt_ready=0; key3 posts SHORT then DOUBLE before acceptance
//        -> ovf_pulse once, delivered event key=3 type=11.
//   6. rst_n low for 1 cycle while key1 is in WAIT_DBL and evt_valid=1
//        -> all outputs 0 immediately, no event after reset release.

Source files
------------

// File: rtl/key_event_ctrl.sv
// rtl/key_event_ctrl.sv - per-key short/long/double-click event generator with round-robin output
//
// Purpose: each key has a timing FSM that classifies debounced press/release activity
//   into SHORT (01), LONG (10), DOUBLE (11) and, when KEY_EVT_REPEAT_EN is defined,
//   auto-REPEAT (00) events. Every key owns a one-deep pending slot. A round-robin
//   arbiter moves one slot per cycle into a valid/ready output register.
// Optional feature: define KEY_EVT_REPEAT_EN to post REPEAT events while a key is held
//   after a LONG. Without it, HELD just waits for release.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   key_state  debounced level per key, 1 = pressed
//   key_flag   1-cycle press pulse per key, coincides with the key_state rise
//   evt_valid  event available
//   evt_ready  consumer accepts when evt_valid & evt_ready
//   evt_key    key index of the presented event
//   evt_type   01 short, 10 long, 11 double, 00 repeat
//   ovf_pulse  1-cycle pulse: a pending, not yet granted event was overwritten
module key_event_ctrl #(
  parameter int NUM_KEYS   = 4,
  parameter int KEY_W      = 2,
  parameter int LONG_CNT   = 50_000_000,
  parameter int DBL_CNT    = 15_000_000,
  parameter int REPEAT_CNT = 10_000_000,
  parameter int CNT_WIDTH  = 26
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_state,
  input  logic [NUM_KEYS-1:0] key_flag,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [KEY_W-1:0]    evt_key,
  output logic [1:0]          evt_type,
  output logic                ovf_pulse
);

  if (NUM_KEYS < 1 || NUM_KEYS > 16 || KEY_W < 1 || (longint'(1) << KEY_W) < longint'(NUM_KEYS) ||
      LONG_CNT < 1 || DBL_CNT < 1 || REPEAT_CNT < 1 ||
      longint'(LONG_CNT) > (longint'(1) << CNT_WIDTH) ||
      longint'(DBL_CNT) > (longint'(1) << CNT_WIDTH) ||
      longint'(REPEAT_CNT) > (longint'(1) << CNT_WIDTH)) begin : g_bad_params
    $error("key_event_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_WAIT_DBL, S_HELD} key_st_e;

  localparam logic [1:0] T_REPEAT = 2'b00;
  localparam logic [1:0] T_SHORT  = 2'b01;
  localparam logic [1:0] T_LONG   = 2'b10;
  localparam logic [1:0] T_DOUBLE = 2'b11;
  localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_CNT - 1);
  localparam logic [CNT_WIDTH-1:0] DBL_LAST  = CNT_WIDTH'(DBL_CNT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  key_st_e                      state_q [NUM_KEYS];
  key_st_e                      state_d [NUM_KEYS];
  logic [CNT_WIDTH-1:0]         cnt_q   [NUM_KEYS];
  logic [CNT_WIDTH-1:0]         cnt_d   [NUM_KEYS];
  logic [NUM_KEYS-1:0]          key_state_d;
  logic [NUM_KEYS-1:0]          key_rel;
  logic [NUM_KEYS-1:0]          post;
  logic [NUM_KEYS-1:0][1:0]     post_type;
  logic [NUM_KEYS-1:0]          slot_valid_q;
  logic [NUM_KEYS-1:0][1:0]     slot_type_q;
  logic [NUM_KEYS-1:0]          grant_clr;
  logic [KEY_W-1:0]             rr_q;
  logic                         out_free;
  logic                         hi_any, lo_any, grant_any;
  logic [KEY_W-1:0]             hi_idx, lo_idx, grant_idx, rr_next;
  logic [1:0]                   hi_type, lo_type, grant_type;
`ifdef KEY_EVT_REPEAT_EN
  localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_CNT - 1);
  // Set when HELD was entered through a LONG; only then does the hold auto-repeat.
  logic [NUM_KEYS-1:0]          rpt_q, rpt_d;
`endif

  assign key_rel = key_state_d & ~key_state;

  // Per-key timing FSMs (next state, timer and event post).
  always_comb begin
`ifdef KEY_EVT_REPEAT_EN
    rpt_d = rpt_q;
`endif
    post      = '0;
    post_type = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      state_d[k]   = state_q[k];
      cnt_d[k]     = cnt_q[k] + CNT_ONE;
      post_type[k] = T_SHORT;
      unique case (state_q[k])
        S_IDLE: begin
          cnt_d[k] = '0;
          if (key_flag[k]) state_d[k] = S_PRESSED;
        end
        S_PRESSED: begin
          if (cnt_q[k] == LONG_LAST) begin
            post[k]      = 1'b1;
            post_type[k] = T_LONG;
            cnt_d[k]     = '0;
            state_d[k]   = key_rel[k] ? S_IDLE : S_HELD;
`ifdef KEY_EVT_REPEAT_EN
            rpt_d[k]     = 1'b1;
`endif
          end else if (key_rel[k]) begin
            cnt_d[k]   = '0;
            state_d[k] = S_WAIT_DBL;
          end
        end
        S_WAIT_DBL: begin
          // A repress on the very cycle the window closes still counts as a double.
          if (key_flag[k]) begin
            post[k]      = 1'b1;
            post_type[k] = T_DOUBLE;
            cnt_d[k]     = '0;
            state_d[k]   = S_HELD;
`ifdef KEY_EVT_REPEAT_EN
            rpt_d[k]     = 1'b0;
`endif
          end else if (cnt_q[k] == DBL_LAST) begin
            post[k]      = 1'b1;
            post_type[k] = T_SHORT;
            cnt_d[k]     = '0;
            state_d[k]   = S_IDLE;
          end
        end
        S_HELD: begin
          if (key_rel[k]) begin
            cnt_d[k]   = '0;
            state_d[k] = S_IDLE;
          end else begin
`ifdef KEY_EVT_REPEAT_EN
            if (rpt_q[k] && cnt_q[k] == REPEAT_LAST) begin
              post[k]      = 1'b1;
              post_type[k] = T_REPEAT;
              cnt_d[k]     = '0;
            end
`else
            cnt_d[k] = cnt_q[k];
`endif
          end
        end
        default: begin
          cnt_d[k]   = '0;
          state_d[k] = S_IDLE;
        end
      endcase
    end
  end

  // Round-robin search: lowest valid slot at or above rr_q, else lowest valid slot overall.
  always_comb begin
    hi_any  = 1'b0;
    lo_any  = 1'b0;
    hi_idx  = '0;
    lo_idx  = '0;
    hi_type = '0;
    lo_type = '0;
    for (int j = NUM_KEYS - 1; j >= 0; j--) begin
      if (slot_valid_q[j]) begin
        lo_any  = 1'b1;
        lo_idx  = KEY_W'(j);
        lo_type = slot_type_q[j];
        if (KEY_W'(j) >= rr_q) begin
          hi_any  = 1'b1;
          hi_idx  = KEY_W'(j);
          hi_type = slot_type_q[j];
        end
      end
    end
    grant_any  = lo_any;
    grant_idx  = hi_any ? hi_idx : lo_idx;
    grant_type = hi_any ? hi_type : lo_type;
    rr_next    = (grant_idx == KEY_W'(NUM_KEYS - 1)) ? '0 : grant_idx + KEY_W'(1);
    out_free   = !evt_valid || evt_ready;
    for (int k = 0; k < NUM_KEYS; k++) begin
      grant_clr[k] = out_free && grant_any && (grant_idx == KEY_W'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        state_q[k] <= S_IDLE;
        cnt_q[k]   <= '0;
      end
`ifdef KEY_EVT_REPEAT_EN
      rpt_q        <= '0;
`endif
      key_state_d  <= '0;
      slot_valid_q <= '0;
      slot_type_q  <= '0;
      rr_q         <= '0;
      evt_valid    <= 1'b0;
      evt_key      <= '0;
      evt_type     <= '0;
      ovf_pulse    <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
        // A new post beats the grant clear so a same-cycle event is never lost.
        if (post[k]) begin
          slot_valid_q[k] <= 1'b1;
          slot_type_q[k]  <= post_type[k];
        end else if (grant_clr[k]) begin
          slot_valid_q[k] <= 1'b0;
        end
      end
`ifdef KEY_EVT_REPEAT_EN
      rpt_q        <= rpt_d;
`endif
      key_state_d  <= key_state;
      ovf_pulse    <= |(post & slot_valid_q & ~grant_clr);
      if (out_free) begin
        evt_valid <= grant_any;
        if (grant_any) begin
          evt_key  <= grant_idx;
          evt_type <= grant_type;
          rr_q     <= rr_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// tb/tb_key_event_ctrl.sv - scoreboard testbench for key_event_ctrl
module tb_key_event_ctrl;

  localparam int NK   = 4;
  localparam int LONG = 100;
  localparam int DBL  = 30;
  localparam int REP  = 20;

  typedef struct {
    int         key;
    logic [1:0] typ;
    int         t;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ks = '0;
  logic [3:0] kf = '0;
  logic       evt_ready = 1'b1;
  logic       evt_valid;
  logic [1:0] evt_key;
  logic [1:0] evt_type;
  logic       ovf_pulse;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   lat_mode = 0;
  int   ovf_seen = 0;
  exp_t sb[$];
  int   deliv_log[$];
  int   deliv_cyc[$];

  // Reference model: timestamps of the last press/release per key.
  int   mode [NK];
  bit   wait_dbl [NK];
  int   press_t [NK];
  int   rel_t [NK];
  int   long_t [NK];

  key_event_ctrl #(
    .NUM_KEYS(NK), .KEY_W(2), .LONG_CNT(LONG), .DBL_CNT(DBL),
    .REPEAT_CNT(REP), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_state(ks), .key_flag(kf),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key),
    .evt_type(evt_type), .ovf_pulse(ovf_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void push_exp(input int k, input logic [1:0] ty, input int t);
    exp_t e;
    e.key = k; e.typ = ty; e.t = t;
    sb.push_back(e);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NK; k++) begin
      mode[k] = 0; wait_dbl[k] = 1'b0; press_t[k] = 0; rel_t[k] = 0; long_t[k] = 0;
    end
  endfunction

  // mode: 0 released, 1 pressing (long not yet reached), 2 held after long, 3 held after double
  function automatic void model_step(input int c, input logic [3:0] fl, input logic [3:0] rl);
    for (int k = 0; k < NK; k++) begin
      if (mode[k] == 1 && c == press_t[k] + LONG) begin
        push_exp(k, 2'b10, c); mode[k] = 2; long_t[k] = c;
      end
      if (fl[k]) begin
        if (wait_dbl[k] && c <= rel_t[k] + DBL) begin
          push_exp(k, 2'b11, c); mode[k] = 3;
        end else begin
          mode[k] = 1; press_t[k] = c;
        end
        wait_dbl[k] = 1'b0;
      end else if (rl[k]) begin
        if (mode[k] == 1) begin wait_dbl[k] = 1'b1; rel_t[k] = c; end
        mode[k] = 0;
      end else begin
        if (wait_dbl[k] && c == rel_t[k] + DBL) begin
          push_exp(k, 2'b01, c); wait_dbl[k] = 1'b0;
        end
`ifdef KEY_EVT_REPEAT_EN
        if (mode[k] == 2 && c > long_t[k] && (c - long_t[k]) % REP == 0) push_exp(k, 2'b00, c);
`endif
      end
    end
  endfunction

  function automatic void drop_first(input int k);
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].key == k) begin sb.delete(i); return; end
    end
  endfunction

  task automatic step(input logic [3:0] nxt);
    logic [3:0] rl;
    @(posedge clk); #1;
    rl = ks & ~nxt;
    kf = nxt & ~ks;
    ks = nxt;
    model_step(cyc, kf, rl);
  endtask

  task automatic idle(input int n);
    repeat (n) step(ks);
  endtask

  task automatic hold_key(input int k, input int h);
    logic [3:0] v;
    v = ks; v[k] = 1'b1; step(v);
    repeat (h - 1) step(ks);
    v = ks; v[k] = 1'b0; step(v);
  endtask

  function automatic int pick_hold();
    case ($urandom_range(0, 2))
      0:       return int'($urandom_range(5, 40));
      1:       return int'($urandom_range(95, 105));
      default: return int'($urandom_range(110, 170));
    endcase
  endfunction

  function automatic int pick_gap();
    if ($urandom_range(0, 1) == 0) return int'($urandom_range(5, 35));
    return int'($urandom_range(40, 80));
  endfunction

  // Monitor: pops the scoreboard on every accepted event, checks stall stability.
  logic       prev_stall = 1'b0;
  logic [1:0] prev_key = '0;
  logic [1:0] prev_type = '0;
  int         mon_idx;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!evt_valid || evt_key != prev_key || evt_type != prev_type) begin
          errors++;
          $display("FAIL hold_stable: valid=%0b key=%0d type=%0d, expected valid=1 key=%0d type=%0d",
                   evt_valid, evt_key, evt_type, prev_key, prev_type);
        end
      end
      if (ovf_pulse) ovf_seen++;
      if (evt_valid && evt_ready) begin
        deliv_log.push_back(int'(evt_key));
        deliv_cyc.push_back(cyc);
        mon_idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
          if (mon_idx < 0 && sb[i].key == int'(evt_key)) mon_idx = i;
        end
        checks++;
        if (mon_idx < 0) begin
          errors++;
          $display("FAIL unexpected_evt: key=%0d type=%0d at cycle %0d, expected none",
                   evt_key, evt_type, cyc);
        end else begin
          mon_e = sb[mon_idx];
          sb.delete(mon_idx);
          if (evt_type != mon_e.typ) begin
            errors++;
            $display("FAIL evt_type key%0d: got %0d, expected %0d", evt_key, evt_type, mon_e.typ);
          end
          if (lat_mode == 1) begin
            checks++;
            if (cyc != mon_e.t + 2) begin
              errors++;
              $display("FAIL latency key%0d: got cycle %0d, expected %0d", evt_key, cyc, mon_e.t + 2);
            end
          end else if (lat_mode == 2) begin
            checks++;
            if (cyc < mon_e.t + 2 || cyc > mon_e.t + 1 + NK) begin
              errors++;
              $display("FAIL latency_window key%0d: got cycle %0d, expected %0d..%0d",
                       evt_key, cyc, mon_e.t + 2, mon_e.t + 1 + NK);
            end
          end
        end
      end
      prev_stall = evt_valid && !evt_ready;
      prev_key   = evt_key;
      prev_type  = evt_type;
    end
  end

  int         left [NK];
  logic [3:0] nxt;
  int         ovf_base;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_evt_valid", int'(evt_valid), 0);
    chk("reset_evt_key", int'(evt_key), 0);
    chk("reset_evt_type", int'(evt_type), 0);
    chk("reset_ovf", int'(ovf_pulse), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed single-key cases with exact latency.
    lat_mode = 1;
    hold_key(1, 20); idle(40);
    chk("t1_drain", sb.size(), 0);
    hold_key(0, 150); idle(40);
    chk("t2_drain", sb.size(), 0);
    hold_key(2, 10); idle(11); hold_key(2, 10); idle(40);
    chk("t3_drain", sb.size(), 0);

    // Randomised concurrent key activity.
    lat_mode = 2;
    ovf_base = ovf_seen;
    for (int k = 0; k < NK; k++) left[k] = int'($urandom_range(1, 20));
    for (int c = 0; c < 4000; c++) begin
      nxt = ks;
      for (int k = 0; k < NK; k++) begin
        if (left[k] == 0) begin
          nxt[k]  = ~ks[k];
          left[k] = (nxt[k] ? pick_hold() : pick_gap()) - 1;
        end else begin
          left[k]--;
        end
      end
      step(nxt);
    end
    step(4'h0);
    idle(60);
    chk("rand_drain", sb.size(), 0);
    chk("rand_ovf", ovf_seen - ovf_base, 0);

    // All keys post together under back-pressure.
    lat_mode = 0;
    evt_ready = 1'b0;
    deliv_log.delete(); deliv_cyc.delete();
    ovf_base = ovf_seen;
    step(4'hF); idle(9); step(4'h0);
    idle(41);
    evt_ready = 1'b1;
    idle(10);
    chk("t4_count", deliv_log.size(), 4);
    if (deliv_log.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t4_order", deliv_log[i], i);
      for (int i = 1; i < 4; i++) chk("t4_back_to_back", deliv_cyc[i] - deliv_cyc[i-1], 1);
    end
    chk("t4_ovf", ovf_seen - ovf_base, 0);
    chk("t4_drain", sb.size(), 0);

    // Pending SHORT on key3 overwritten by a DOUBLE while the output is stalled.
    evt_ready = 1'b0;
    deliv_log.delete(); deliv_cyc.delete();
    ovf_base = ovf_seen;
    hold_key(0, 10); idle(35);
    hold_key(3, 10); idle(35);
    hold_key(3, 10); idle(5); hold_key(3, 10); idle(5);
    chk("t5_ovf_once", ovf_seen - ovf_base, 1);
    drop_first(3);
    evt_ready = 1'b1;
    idle(10);
    chk("t5_count", deliv_log.size(), 2);
    if (deliv_log.size() == 2) begin
      chk("t5_first_key", deliv_log[0], 0);
      chk("t5_second_key", deliv_log[1], 3);
    end
    chk("t5_drain", sb.size(), 0);

    // Reset while key1 waits for a double click and an event is presented.
    evt_ready = 1'b0;
    hold_key(0, 10); idle(35);
    chk("t6_pre_valid", int'(evt_valid), 1);
    hold_key(1, 10); idle(5);
    deliv_log.delete(); deliv_cyc.delete();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", int'(evt_valid), 0);
    chk("t6_rst_key", int'(evt_key), 0);
    chk("t6_rst_type", int'(evt_type), 0);
    chk("t6_rst_ovf", int'(ovf_pulse), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    model_reset();
    evt_ready = 1'b1;
    idle(60);
    chk("t6_no_event", deliv_log.size(), 0);
    chk("t6_valid_low", int'(evt_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
